// File: rtl/pipelined_alu_ctrl_md.sv
// Registered ALU-control decode stage with mult/div and HI/LO-read decode, a valid/ready
// output slot, and a busy tracker that holds dependent entries until the mult/div unit is free.
module pipelined_alu_ctrl_md #(
  parameter int CTRL_W     = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_aluop,
  input  logic [5:0]        in_func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic              out_rtype_err,
  output logic              out_is_md,
  output logic              md_busy,
  output logic              err_sticky,
  input  logic              err_clr
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

  // Decode of the incoming request
  logic [4:0] dec_code;
  logic       dec_err;
  logic       dec_is_md;
  logic       dec_is_div;
  logic       dec_is_hilo;

  // Output slot and tracker state
  logic              full_q, full_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              err_q, err_d;
  logic              is_md_q, is_md_d;
  logic              is_div_q, is_div_d;
  logic              is_hilo_q, is_hilo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              err_sticky_q, err_sticky_d;

  logic hold;
  logic in_fire;
  logic out_fire;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    dec_code    = 5'b0_0000;
    dec_err     = 1'b0;
    dec_is_md   = 1'b0;
    dec_is_div  = 1'b0;
    dec_is_hilo = 1'b0;
    if (in_aluop != ALUOP_RTYPE) begin
      dec_code = {1'b0, in_aluop};
    end else begin
      unique case (in_func)
        6'b000000: dec_code = 5'b0_0011;
        6'b000010: dec_code = 5'b0_0100;
        6'b000011: dec_code = 5'b0_1101;
        6'b100000: dec_code = 5'b0_0010;
        6'b100001: dec_code = 5'b0_1000;
        6'b100010: dec_code = 5'b0_0110;
        6'b100011: dec_code = 5'b0_1001;
        6'b100100: dec_code = 5'b0_0000;
        6'b100101: dec_code = 5'b0_0001;
        6'b100110: dec_code = 5'b0_1010;
        6'b100111: dec_code = 5'b0_1100;
        6'b101010: dec_code = 5'b0_0111;
        6'b101011: dec_code = 5'b0_1011;
        6'b001000: dec_code = 5'b0_0000;
        6'b011000: begin dec_code = 5'b1_0000; dec_is_md = 1'b1; end
        6'b011001: begin dec_code = 5'b1_0001; dec_is_md = 1'b1; end
        6'b011010: begin dec_code = 5'b1_0010; dec_is_md = 1'b1; dec_is_div = 1'b1; end
        6'b011011: begin dec_code = 5'b1_0011; dec_is_md = 1'b1; dec_is_div = 1'b1; end
        6'b010000: begin dec_code = 5'b1_0100; dec_is_hilo = 1'b1; end
        6'b010010: begin dec_code = 5'b1_0101; dec_is_hilo = 1'b1; end
        default:   dec_err  = 1'b1;
      endcase
    end
  end

  // Handshakes: an entry that needs the mult/div unit waits while it is busy
  always_comb begin
    hold      = full_q && (is_md_q || is_hilo_q) && md_busy;
    out_valid = full_q && !hold;
    out_fire  = out_valid && out_ready;
    in_ready  = !full_q || out_fire;
    in_fire   = in_valid && in_ready;
  end

  always_comb begin
    full_d       = full_q;
    ctrl_d       = ctrl_q;
    err_d        = err_q;
    is_md_d      = is_md_q;
    is_div_d     = is_div_q;
    is_hilo_d    = is_hilo_q;
    err_sticky_d = err_sticky_q;
    if (in_fire) begin
      full_d    = 1'b1;
      ctrl_d    = CTRL_W'(dec_code);
      err_d     = dec_err;
      is_md_d   = dec_is_md;
      is_div_d  = dec_is_div;
      is_hilo_d = dec_is_hilo;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
    // Set has priority over a simultaneous clear
    if (out_fire && err_q) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  // Busy tracker: state register
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy tracker: next state
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && is_md_q) begin
      cnt_d = is_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    state_d = (cnt_d != '0) ? S_BUSY : S_IDLE;
  end

  // Busy tracker: outputs
  always_comb begin
    md_busy = (state_q == S_BUSY);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      full_q       <= 1'b0;
      ctrl_q       <= '0;
      err_q        <= 1'b0;
      is_md_q      <= 1'b0;
      is_div_q     <= 1'b0;
      is_hilo_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      ctrl_q       <= ctrl_d;
      err_q        <= err_d;
      is_md_q      <= is_md_d;
      is_div_q     <= is_div_d;
      is_hilo_q    <= is_hilo_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_alu_ctrl  = ctrl_q;
  assign out_rtype_err = err_q;
  assign out_is_md     = is_md_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: doc/pipelined_alu_ctrl_md.md
Name: pipelined_alu_ctrl_md

Overview:
Registered ALU-control decode stage for the pipelined MIPS datapath, the parametrised successor to the combinational ALU-control decoder. Maps ALUop/funct to an ALU control code, adds multiply/divide and HI/LO-read decode, and uses a valid/ready handshake toward EX. Tracks the multi-cycle multiply/divide unit with a busy counter and holds dependent HI/LO reads and new mult/div ops until that unit is free. Flags illegal R-type functs per instruction and in a sticky flag.

Parameters:
CTRL_W, 5, width of ALU control code; legal values are 5 and above; legacy 4-bit codes are zero-extended.
MUL_CYCLES, 4, busy cycles after a MULT/MULTU issue; legal range is 1 to 2^CNT_W-1.
DIV_CYCLES, 32, busy cycles after a DIV/DIVU issue; same legal range.
CNT_W, 6, busy counter width.

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
in_valid  in  1  decode request valid
in_ready  out  1  stage can accept
in_aluop  in  4  ALUop from main control; 4'b1111 = R-type
in_func  in  6  instruction funct field
out_valid  out  1  decoded entry valid to EX
out_ready  in  1  EX accepts
out_alu_ctrl  out  CTRL_W  ALU control code
out_rtype_err  out  1  entry is an unknown R-type funct
out_is_md  out  1  entry is MULT/MULTU/DIV/DIVU
md_busy  out  1  mult/div unit busy
err_sticky  out  1  sticky illegal-funct flag
err_clr  in  1  clears err_sticky

Behaviour:
- Decode, combinational, captured on input handshake (in_valid && in_ready):
  - aluop != 4'b1111: ctrl = zero-extended aluop; err = 0.
  - R-type funct to code:
    - 000000 -> 0011; 000010 -> 0100; 000011 -> 1101.
    - 100000 -> 0010; 100001 -> 1000; 100010 -> 0110; 100011 -> 1001.
    - 100100 -> 0000; 100101 -> 0001; 100110 -> 1010; 100111 -> 1100.
    - 101010 -> 0111; 101011 -> 1011.
    - JR 001000 -> 0, err = 0.
    - 011000 MULT -> 1_0000; 011001 MULTU -> 1_0001; 011010 DIV -> 1_0010; 011011 DIVU -> 1_0011.
    - 010000 MFHI -> 1_0100; 010010 MFLO -> 1_0101.
    - Any other funct -> ctrl 0, err 1. No X is ever driven.
- Output register:
  - One entry; flag `full`. Latency is 1 cycle from input handshake to out_valid, when not held.
  - hold = full && (entry is mult/div or MFHI/MFLO) && md_busy.
  - out_valid = full && !hold.
  - in_ready = !full || (out_valid && out_ready). This gives full throughput and back-to-back acceptance.
  - While out_valid && !out_ready, the entry and all out_* fields stay stable.
- Busy FSM:
  - States: IDLE (cnt == 0) and BUSY (cnt != 0). md_busy = (cnt != 0).
  - Output handshake of MULT/MULTU loads cnt = MUL_CYCLES; DIV/DIVU loads cnt = DIV_CYCLES. Otherwise cnt decrements each cycle while non-zero.
  - md_busy is therefore high for exactly N cycles starting the cycle after issue.
  - A load cannot coincide with a non-zero cnt, because issue is held while busy.
- err_sticky:
  - Set on an output handshake of an entry with err = 1.
  - err_clr clears it. If set and clear happen in the same cycle, set wins.
- Reset:
  - full, cnt and err_sticky are cleared; out_alu_ctrl, out_rtype_err and out_is_md go to 0.
  - out_valid = 0, md_busy = 0, in_ready = 1 on the cycle after Reset.
  - Reset during BUSY or during a hold discards the entry and the count.

Test Plan:
- Reset, then ADD R-type (aluop F, func 100000) with out_ready=1 -> next cycle out_valid=1, ctrl 00010, err 0; in_ready stays 1 throughout.
- aluop 0010, then funct 111111 -> ctrl 00010 err 0; then ctrl 0 err 1; err_sticky=1 after the second handshake; err_clr pulse -> err_sticky 0.
- MULT issued, then MFLO immediately, defaults -> md_busy high 4 cycles; MFLO out_valid=0 and in_ready=0 during busy; MFLO out_valid=1 with ctrl 10101 in the cycle md_busy returns to 0.
- DIV then DIVU back-to-back -> second op held exactly 32 cycles after the first issue, then issues and reloads 32.
- out_ready=0 for 3 cycles with SUB registered -> out_valid held, ctrl 00110 stable, in_ready=0; SUB accepted on the cycle out_ready=1.
- Reset asserted mid-DIV busy (cnt=10) with MFHI held -> next cycle md_busy=0, out_valid=0, in_ready=1.
